// File: rtl/seg_refresh_sched.sv
// seg_refresh_sched: arbitrates CPU updates and periodic refresh onto the
// shared 7-seg serial path, holds the shadow image, pulses Start, blinks.
// Ports:
//   clk, rst           clock, async active-low reset
//   upd_req/upd_*      CPU update request (level) and its data
//   upd_ack            one-cycle pulse, update latched into shadow
//   p2s_busy           shifter busy while shifting
//   Start              one-cycle shift start pulse
//   Hexs/point/LES/Text shadow display image
//   flash              blink square wave
//   busy               scheduler not idle
//   timeout_err        sticky, shifter never went busy after Start
module seg_refresh_sched #(
  parameter int REFRESH_DIV  = 50000,
  parameter int FLASH_DIV    = 25000000,
  parameter int BUSY_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_req,
  input  logic [31:0] upd_hexs,
  input  logic [7:0]  upd_point,
  input  logic [7:0]  upd_les,
  input  logic        upd_text,
  output logic        upd_ack,
  input  logic        p2s_busy,
  output logic        Start,
  output logic [31:0] Hexs,
  output logic [7:0]  point,
  output logic [7:0]  LES,
  output logic        Text,
  output logic        flash,
  output logic        busy,
  output logic        timeout_err
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [RW-1:0] RTC = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FTC = FW'(FLASH_DIV - 1);
  localparam logic [TW-1:0] TTC = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    KICK,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [RW-1:0] rcnt;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic          refresh_pend;
  logic          rtc;
  logic          ftc;

  assign rtc = (rcnt == RTC);
  assign ftc = (fcnt == FTC);

  // Refresh timer; a terminal count in the same cycle as the KICK
  // clear wins, so a request landing mid-launch is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt         <= '0;
      refresh_pend <= 1'b0;
    end else begin
      rcnt <= rtc ? '0 : rcnt + RW'(1);
      if (rtc)
        refresh_pend <= 1'b1;
      else if (state == KICK)
        refresh_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt  <= '0;
      flash <= 1'b0;
    end else begin
      fcnt <= ftc ? '0 : fcnt + FW'(1);
      if (ftc)
        flash <= ~flash;
    end
  end

  // Outputs are registered on the transition into the state that owns
  // them, so upd_ack/shadow appear in LATCH and Start in KICK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      Start       <= 1'b0;
      upd_ack     <= 1'b0;
      Hexs        <= '0;
      point       <= '0;
      LES         <= 8'h00;
      Text        <= 1'b1;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      Start   <= 1'b0;
      upd_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (upd_req) begin
            state   <= LATCH;
            upd_ack <= 1'b1;
            Hexs    <= upd_hexs;
            point   <= upd_point;
            LES     <= upd_les;
            Text    <= upd_text;
            busy    <= 1'b1;
          end else if (refresh_pend) begin
            state <= KICK;
            Start <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LATCH: begin
          state <= KICK;
          Start <= 1'b1;
        end
        KICK: begin
          state <= WAIT_BUSY;
          tcnt  <= '0;
        end
        WAIT_BUSY: begin
          if (p2s_busy) begin
            state <= WAIT_DONE;
          end else if (tcnt == TTC) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!p2s_busy) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_refresh_sched.sv
// tb_seg_refresh_sched: directed checks of refresh/update scheduling,
// timeout and async reset with a 10-cycle shifter model.
module tb_seg_refresh_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        upd_req = 1'b0;
  logic [31:0] upd_hexs = '0;
  logic [7:0]  upd_point = '0;
  logic [7:0]  upd_les = '0;
  logic        upd_text = 1'b0;
  logic        upd_ack;
  logic        p2s_busy;
  logic        Start;
  logic [31:0] Hexs;
  logic [7:0]  point;
  logic [7:0]  LES;
  logic        Text;
  logic        flash;
  logic        busy;
  logic        timeout_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit shifter_on = 1'b1;
  int bcnt;

  seg_refresh_sched #(
    .REFRESH_DIV (16),
    .FLASH_DIV   (8),
    .BUSY_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_req    (upd_req),
    .upd_hexs   (upd_hexs),
    .upd_point  (upd_point),
    .upd_les    (upd_les),
    .upd_text   (upd_text),
    .upd_ack    (upd_ack),
    .p2s_busy   (p2s_busy),
    .Start      (Start),
    .Hexs       (Hexs),
    .point      (point),
    .LES        (LES),
    .Text       (Text),
    .flash      (flash),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Shifter: busy rises one cycle after Start and stays for 10 cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst)
      bcnt <= 0;
    else if (Start && shifter_on)
      bcnt <= 10;
    else if (bcnt != 0)
      bcnt <= bcnt - 1;
  end
  assign p2s_busy = (bcnt != 0);

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    upd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_start(input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!Start && n < maxc);
  endtask

  task automatic set_upd(input logic [31:0] h, input logic [7:0] p,
                         input logic [7:0] l, input logic t);
    upd_req   = 1'b1;
    upd_hexs  = h;
    upd_point = p;
    upd_les   = l;
    upd_text  = t;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_start"}, Start, 1'b0);
    chk({tag, "_ack"}, upd_ack, 1'b0);
    chk({tag, "_hexs"}, Hexs, 32'h0);
    chk({tag, "_point"}, point, 8'h0);
    chk({tag, "_les"}, LES, 8'h00);
    chk({tag, "_text"}, Text, 1'b1);
    chk({tag, "_flash"}, flash, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_terr"}, timeout_err, 1'b0);
  endtask

  initial begin
    int n;
    int starts;
    bit sh_bad;

    // Idle refresh and flash
    do_reset();
    check_reset_outs("rst");
    starts = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      starts += int'(Start);
      if (i == 7) chk("a_flash7", flash, 1'b0);
      if (i == 8) chk("a_flash8", flash, 1'b1);
      if (i == 16) chk("a_flash16", flash, 1'b0);
    end
    chk("a_start17", Start, 1'b1);
    chk("a_starts", starts, 1);
    chk("a_hexs", Hexs, 32'h0);
    chk("a_text", Text, 1'b1);
    wait_start(40, n);
    chk("a_period", n, 16);

    // Update in idle
    do_reset();
    tick();
    tick();
    set_upd(32'h12345678, 8'h0F, 8'hAA, 1'b0);
    tick();
    chk("b_ack", upd_ack, 1'b1);
    chk("b_nostart", Start, 1'b0);
    chk("b_hexs", Hexs, 32'h12345678);
    chk("b_point", point, 8'h0F);
    chk("b_les", LES, 8'hAA);
    chk("b_text", Text, 1'b0);
    chk("b_busy", busy, 1'b1);
    upd_req = 1'b0;
    tick();
    chk("b_start", Start, 1'b1);
    chk("b_ack_off", upd_ack, 1'b0);
    wait_start(40, n);
    chk("b_next", n, 13);
    chk("b_hexs_keep", Hexs, 32'h12345678);

    // Terminal count lands on KICK: pending refresh survives
    do_reset();
    repeat (13) tick();
    set_upd(32'hDEADBEEF, 8'h11, 8'h22, 1'b1);
    tick();
    chk("c_ack", upd_ack, 1'b1);
    upd_req = 1'b0;
    tick();
    chk("c_start", Start, 1'b1);
    wait_start(40, n);
    chk("c_setwins", n, 13);

    // Update wins over a refresh pending in the same cycle
    do_reset();
    repeat (16) tick();
    set_upd(32'h0BADF00D, 8'h33, 8'h44, 1'b0);
    tick();
    chk("d_ack", upd_ack, 1'b1);
    chk("d_nostart", Start, 1'b0);
    upd_req = 1'b0;
    tick();
    chk("d_start", Start, 1'b1);
    wait_start(40, n);
    chk("d_next", n, 15);

    // Update arriving during WAIT_DONE waits for idle
    do_reset();
    tick();
    tick();
    set_upd(32'h12345678, 8'h0F, 8'hAA, 1'b0);
    tick();
    upd_req = 1'b0;
    tick();
    chk("e_start1", Start, 1'b1);
    starts = 0;
    sh_bad = 1'b0;
    for (int i = 5; i <= 16; i++) begin
      tick();
      if (i == 8) set_upd(32'hCAFEF00D, 8'hF0, 8'h55, 1'b1);
      starts += int'(Start);
      if (Hexs != 32'h12345678) sh_bad = 1'b1;
    end
    chk("e_nostart", starts, 0);
    chk("e_shadow_hold", sh_bad, 1'b0);
    tick();
    chk("e_ack", upd_ack, 1'b1);
    chk("e_hexs", Hexs, 32'hCAFEF00D);
    chk("e_text", Text, 1'b1);
    upd_req = 1'b0;
    tick();
    chk("e_start2", Start, 1'b1);
    wait_start(40, n);
    chk("e_next", n, 15);

    // Shifter never responds
    shifter_on = 1'b0;
    do_reset();
    wait_start(40, n);
    chk("f_start", n, 17);
    repeat (4) tick();
    chk("f_terr_early", timeout_err, 1'b0);
    chk("f_busy_early", busy, 1'b1);
    tick();
    chk("f_terr", timeout_err, 1'b1);
    chk("f_idle", busy, 1'b0);
    wait_start(40, n);
    chk("f_next", n, 11);
    chk("f_sticky", timeout_err, 1'b1);
    shifter_on = 1'b1;

    // Async reset mid-shift
    do_reset();
    tick();
    tick();
    set_upd(32'h87654321, 8'hFF, 8'hFF, 1'b0);
    tick();
    upd_req = 1'b0;
    tick();
    chk("g_start", Start, 1'b1);
    repeat (4) tick();
    chk("g_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_reset_outs("g");
    starts = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      starts += int'(Start);
    end
    chk("g_rst_nostart", starts, 0);
    rst = 1'b1;
    wait_start(40, n);
    chk("g_restart", n, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
